// File: rtl/axil_user_seq_bfm.sv
// User-side sequencer for an AXI-Lite master: writes a switch-derived pattern to NUM_REGS
// registers, reads them back and compares, with a per-request timeout and sticky LED status.
module axil_user_seq_bfm #(
  parameter int unsigned             ADDR_W      = 32,
  parameter int unsigned             DATA_W      = 32,
  parameter int unsigned             SW_W        = 15,
  parameter int unsigned             LED_W       = 16,
  parameter int unsigned             NUM_REGS    = 4,
  parameter logic [ADDR_W-1:0]       BASE_ADDR   = '0,
  parameter int unsigned             ADDR_STRIDE = 4,
  parameter int unsigned             TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              mode,
  input  logic [SW_W-1:0]   sw,
  output logic              write,
  output logic [ADDR_W-1:0] user_waddr,
  output logic [DATA_W-1:0] user_wdata,
  input  logic              wr_ready,
  output logic              read,
  output logic [ADDR_W-1:0] user_raddr,
  input  logic [DATA_W-1:0] user_rdata,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [LED_W-1:0]  led,
  output logic [2:0]        state_dbg
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned TC_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned LSB_W = LED_W - 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_WR_GAP = 3'd2,
    S_RD     = 3'd3,
    S_RD_GAP = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [TC_W-1:0]    tcnt, tcnt_nxt;
  logic               fail, fail_nxt;
  logic               tmo, tmo_nxt;
  logic               mode_lat, mode_nxt;
  logic [SW_W-1:0]    sw_lat, sw_nxt;
  logic [LSB_W-1:0]   rdata_q, rdata_nxt;

  logic               start_s1, start_s2, start_d;
  logic               mode_s1, mode_s2;
  logic [SW_W-1:0]    sw_s1, sw_s2;
  logic               start_edge;
  logic               last;
  logic               tmo_hit;
  logic [DATA_W-1:0]  exp_data;
  logic [ADDR_W-1:0]  addr;

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
      mode_s1  <= 1'b0;
      mode_s2  <= 1'b0;
      sw_s1    <= '0;
      sw_s2    <= '0;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
      start_d  <= start_s2;
      mode_s1  <= mode;
      mode_s2  <= mode_s1;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
    end
  end

  assign start_edge = start_s2 & ~start_d;
  assign last       = (idx == IDX_W'(NUM_REGS - 1));
  assign tmo_hit    = (tcnt == TC_W'(TIMEOUT - 1));
  assign exp_data   = DATA_W'(sw_lat) + DATA_W'(idx);
  assign addr       = BASE_ADDR + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      idx      <= '0;
      tcnt     <= '0;
      fail     <= 1'b0;
      tmo      <= 1'b0;
      mode_lat <= 1'b0;
      sw_lat   <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      tcnt     <= tcnt_nxt;
      fail     <= fail_nxt;
      tmo      <= tmo_nxt;
      mode_lat <= mode_nxt;
      sw_lat   <= sw_nxt;
      rdata_q  <= rdata_nxt;
    end
  end

  // Handshake: a request (write/read) is held with stable address/data until the master
  // returns a 1-cycle ready strobe; the request then drops for one gap cycle before the next.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    tcnt_nxt   = tcnt;
    fail_nxt   = fail;
    tmo_nxt    = tmo;
    mode_nxt   = mode_lat;
    sw_nxt     = sw_lat;
    rdata_nxt  = rdata_q;
    write      = 1'b0;
    read       = 1'b0;
    user_waddr = '0;
    user_wdata = '0;
    user_raddr = '0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_edge) begin
          mode_nxt  = mode_s2;
          sw_nxt    = sw_s2;
          idx_nxt   = '0;
          tcnt_nxt  = '0;
          fail_nxt  = 1'b0;
          tmo_nxt   = 1'b0;
          state_nxt = mode_s2 ? S_WR : S_RD;
        end
      end
      S_WR: begin
        write      = 1'b1;
        user_waddr = addr;
        user_wdata = exp_data;
        if (wr_ready) begin
          tcnt_nxt  = '0;
          state_nxt = S_WR_GAP;
        end else if (tmo_hit) begin
          tmo_nxt   = 1'b1;
          fail_nxt  = 1'b1;
          state_nxt = S_FIN;
        end else begin
          tcnt_nxt = tcnt + TC_W'(1);
        end
      end
      S_WR_GAP: begin
        tcnt_nxt = '0;
        if (last) begin
          idx_nxt   = '0;
          state_nxt = S_RD;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = S_WR;
        end
      end
      S_RD: begin
        read       = 1'b1;
        user_raddr = addr;
        if (rd_ready) begin
          rdata_nxt = user_rdata[LSB_W-1:0];
          if (mode_lat && (user_rdata != exp_data)) fail_nxt = 1'b1;
          tcnt_nxt  = '0;
          state_nxt = S_RD_GAP;
        end else if (tmo_hit) begin
          tmo_nxt   = 1'b1;
          fail_nxt  = 1'b1;
          state_nxt = S_FIN;
        end else begin
          tcnt_nxt = tcnt + TC_W'(1);
        end
      end
      S_RD_GAP: begin
        tcnt_nxt = '0;
        if (last) begin
          state_nxt = S_FIN;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = S_RD;
        end
      end
      S_FIN: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign led       = {busy, fail, tmo, rdata_q};
  assign state_dbg = state;

endmodule

// File: tb/tb_axil_user_seq_bfm.sv
// Self-checking bench for axil_user_seq_bfm: echo-slave model, directed scenarios and
// randomized sequences checked against a transaction-level reference model.
module tb_axil_user_seq_bfm;
  localparam int AW = 32, DW = 32, SWW = 15, LW = 16, NR = 4, STRIDE = 4, TMO = 16;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic           mode = 1'b0;
  logic [SWW-1:0] sw = '0;
  logic           write, read, busy, done;
  logic [AW-1:0]  user_waddr, user_raddr;
  logic [DW-1:0]  user_wdata;
  logic [DW-1:0]  user_rdata = '0;
  logic           wr_ready = 1'b0;
  logic           rd_ready = 1'b0;
  logic [LW-1:0]  led;
  logic [2:0]     state_dbg;

  int asserts = 0;
  int failures = 0;

  axil_user_seq_bfm #(
    .ADDR_W(AW), .DATA_W(DW), .SW_W(SWW), .LED_W(LW), .NUM_REGS(NR),
    .ADDR_STRIDE(STRIDE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .sw(sw),
    .write(write), .user_waddr(user_waddr), .user_wdata(user_wdata), .wr_ready(wr_ready),
    .read(read), .user_raddr(user_raddr), .user_rdata(user_rdata), .rd_ready(rd_ready),
    .busy(busy), .done(done), .led(led), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- slave model and monitors ----------------
  int            slave_lat = 3;
  bit            wr_en = 1'b1;
  int            corrupt_idx = -1;
  bit            rd_fixed_en = 1'b0;
  logic [DW-1:0] rd_fixed = '0;
  bit            inject_wr = 1'b0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] obs_wa[$];
  logic [DW-1:0] obs_wd[$];
  logic [AW-1:0] obs_ra[$];
  int            wr_cycles, rd_cycles, done_cnt, both_cnt;
  int            wcnt, rcnt;

  always @(negedge clk) begin
    logic [DW-1:0] v;
    wr_ready = inject_wr;
    rd_ready = 1'b0;
    if (!resetn) begin
      wcnt = 0;
      rcnt = 0;
    end else begin
      if (write && read) both_cnt++;
      if (done) done_cnt++;
      if (write) begin
        wr_cycles++;
        wcnt++;
        if (wr_en && wcnt >= slave_lat) begin
          wr_ready = 1'b1;
          mem[user_waddr] = user_wdata;
          obs_wa.push_back(user_waddr);
          obs_wd.push_back(user_wdata);
          wcnt = 0;
        end
      end else wcnt = 0;
      if (read) begin
        rd_cycles++;
        rcnt++;
        if (rcnt >= slave_lat) begin
          if (rd_fixed_en) v = rd_fixed;
          else if (mem.exists(user_raddr)) v = mem[user_raddr];
          else v = '0;
          if (obs_ra.size() == corrupt_idx) v = '0;
          rd_ready = 1'b1;
          user_rdata = v;
          obs_ra.push_back(user_raddr);
          rcnt = 0;
        end
      end else rcnt = 0;
    end
  end

  // ---------------- reference model ----------------
  logic [AW-1:0] exp_wa_q[$];
  logic [DW-1:0] exp_wd_q[$];
  logic [AW-1:0] exp_ra_q[$];
  logic [DW-1:0] exp_last;
  bit            exp_fail;

  task automatic build_model(input bit m, input logic [SWW-1:0] s);
    logic [DW-1:0] ret, want;
    exp_wa_q.delete(); exp_wd_q.delete(); exp_ra_q.delete();
    exp_fail = 1'b0;
    exp_last = '0;
    for (int i = 0; i < NR; i++) begin
      want = DW'(s) + DW'(i);
      if (m) begin
        exp_wa_q.push_back(AW'(i * STRIDE));
        exp_wd_q.push_back(want);
      end
      exp_ra_q.push_back(AW'(i * STRIDE));
      ret = rd_fixed_en ? rd_fixed : want;
      if (i == corrupt_idx) ret = '0;
      if (m && ret != want) exp_fail = 1'b1;
      exp_last = ret;
    end
  endtask

  // ---------------- driver ----------------
  task automatic clear_obs();
    obs_wa.delete(); obs_wd.delete(); obs_ra.delete();
    wr_cycles = 0; rd_cycles = 0; done_cnt = 0; both_cnt = 0;
  endtask

  task automatic do_seq(input bit m, input logic [SWW-1:0] s, output bit ok,
                        output logic [LW-1:0] led_d);
    clear_obs();
    ok = 1'b0;
    led_d = '0;
    @(negedge clk);
    sw = s; mode = m; start = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        led_d = led;
        break;
      end
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    asserts++;
    if ({write, read, busy, done} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0000", {write, read, busy, done});
    end
    asserts++;
    if (led !== '0 || state_dbg !== 3'd0) begin
      failures++; $display("FAIL reset_led_state: led %h state %0d expected 0/0", led, state_dbg);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_wr();
    bit seen = 1'b0;
    wr_en = 1'b0;
    clear_obs();
    sw = 15'h0055; mode = 1'b1; start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (write) begin seen = 1'b1; break; end
    end
    asserts++;
    if (!seen) begin failures++; $display("FAIL t1_write_seen: got 0 expected 1"); end
    #2 resetn = 1'b0;
    #1;
    asserts++;
    if ({write, read, busy, done} !== 4'b0 || led !== '0) begin
      failures++; $display("FAIL t1_async_clear: ctrl %b led %h expected 0", {write, read, busy, done}, led);
    end
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    asserts++;
    if (state_dbg !== 3'd0 || write !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL t1_idle_after: state %0d write %b busy %b expected 0", state_dbg, write, busy);
    end
    wr_en = 1'b1;
  endtask

  task automatic test_write_verify();
    bit ok; logic [LW-1:0] ld;
    slave_lat = 3; corrupt_idx = -1; rd_fixed_en = 1'b0;
    do_seq(1'b1, 15'h1234, ok, ld);
    asserts++;
    if (!ok || done_cnt != 1) begin failures++; $display("FAIL t2_done: seen %b count %0d expected 1/1", ok, done_cnt); end
    asserts++;
    if (obs_wa.size() != 4 || obs_ra.size() != 4) begin
      failures++; $display("FAIL t2_count: wr %0d rd %0d expected 4/4", obs_wa.size(), obs_ra.size());
    end
    for (int i = 0; i < obs_wa.size() && i < 4; i++) begin
      asserts++;
      if (obs_wa[i] !== AW'(4 * i) || obs_wd[i] !== DW'(32'h1234 + i)) begin
        failures++; $display("FAIL t2_wr[%0d]: got %h/%h expected %h/%h", i, obs_wa[i], obs_wd[i], 4 * i, 32'h1234 + i);
      end
    end
    asserts++;
    if (ld[15:13] !== 3'b000 || ld[12:0] !== 13'h1237) begin
      failures++; $display("FAIL t2_led: got %h expected 1237", ld);
    end
    asserts++;
    if (both_cnt != 0) begin failures++; $display("FAIL t2_exclusive: got %0d expected 0", both_cnt); end
  endtask

  task automatic test_corrupt();
    bit ok; logic [LW-1:0] ld;
    corrupt_idx = 2;
    do_seq(1'b1, 15'h1234, ok, ld);
    corrupt_idx = -1;
    asserts++;
    if (!ok || obs_ra.size() != 4) begin failures++; $display("FAIL t3_complete: done %b reads %0d expected 1/4", ok, obs_ra.size()); end
    asserts++;
    if (ld[15:13] !== 3'b010 || ld[12:0] !== 13'h1237) begin
      failures++; $display("FAIL t3_led: got %h expected 5237", ld);
    end
    asserts++;
    if (led[14] !== 1'b1) begin failures++; $display("FAIL t3_sticky: got %b expected 1", led[14]); end
  endtask

  task automatic test_timeout();
    bit ok; logic [LW-1:0] ld;
    wr_en = 1'b0;
    do_seq(1'b1, 15'($urandom), ok, ld);
    wr_en = 1'b1;
    asserts++;
    if (!ok || done_cnt != 1) begin failures++; $display("FAIL t4_done: seen %b count %0d expected 1/1", ok, done_cnt); end
    asserts++;
    if (wr_cycles != TMO) begin failures++; $display("FAIL t4_wr_cycles: got %0d expected %0d", wr_cycles, TMO); end
    asserts++;
    if (rd_cycles != 0) begin failures++; $display("FAIL t4_no_read: got %0d expected 0", rd_cycles); end
    asserts++;
    if (ld[15:13] !== 3'b011) begin failures++; $display("FAIL t4_led: got %b expected 011", ld[15:13]); end
  endtask

  task automatic test_read_only();
    bit ok; logic [LW-1:0] ld;
    rd_fixed_en = 1'b1; rd_fixed = 32'h0000ABCD;
    do_seq(1'b0, 15'($urandom), ok, ld);
    rd_fixed_en = 1'b0;
    asserts++;
    if (wr_cycles != 0 || obs_wa.size() != 0) begin failures++; $display("FAIL t5_no_write: got %0d expected 0", wr_cycles); end
    asserts++;
    if (obs_ra.size() != 4) begin failures++; $display("FAIL t5_reads: got %0d expected 4", obs_ra.size()); end
    for (int i = 0; i < obs_ra.size() && i < 4; i++) begin
      asserts++;
      if (obs_ra[i] !== AW'(4 * i)) begin failures++; $display("FAIL t5_raddr[%0d]: got %h expected %h", i, obs_ra[i], 4 * i); end
    end
    asserts++;
    if (!ok || ld[15:13] !== 3'b000 || ld[12:0] !== 13'h0BCD) begin
      failures++; $display("FAIL t5_led: got %h expected 0bcd", ld);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok; logic [LW-1:0] ld;
    clear_obs();
    slave_lat = 5;
    @(negedge clk);
    sw = 15'h0100; mode = 1'b1; start = 1'b1;
    repeat (6) @(negedge clk);
    repeat (2) begin
      start = 1'b0; repeat (4) @(negedge clk);
      start = 1'b1; repeat (4) @(negedge clk);
    end
    for (int c = 0; c < 300 && done_cnt == 0; c++) @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    asserts++;
    if (done_cnt != 1 || obs_wa.size() != 4) begin
      failures++; $display("FAIL t6_single_seq: done %0d writes %0d expected 1/4", done_cnt, obs_wa.size());
    end
    @(negedge clk); #1 inject_wr = 1'b1;
    @(negedge clk); #1 inject_wr = 1'b0;
    repeat (3) @(negedge clk);
    asserts++;
    if (state_dbg !== 3'd0 || write !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL t6_idle_strobe: state %0d write %b expected 0/0", state_dbg, write);
    end
    slave_lat = 2;
    do_seq(1'b1, 15'h0100, ok, ld);
    asserts++;
    if (obs_wa.size() != 4 || obs_wa[0] !== '0 || obs_wd[0] !== DW'(32'h100)) begin
      failures++; $display("FAIL t6_idx_start: writes %0d first %h expected 4 at 0", obs_wa.size(), obs_wa.size() ? obs_wa[0] : '1);
    end
  endtask

  task automatic test_random();
    bit ok; bit m; logic [SWW-1:0] s; logic [LW-1:0] ld;
    for (int n = 0; n < 10; n++) begin
      m = 1'($urandom_range(0, 1));
      s = SWW'($urandom);
      slave_lat = $urandom_range(1, 5);
      corrupt_idx = (m && $urandom_range(0, 1) == 1) ? $urandom_range(0, NR - 1) : -1;
      rd_fixed_en = !m;
      rd_fixed = $urandom;
      build_model(m, s);
      do_seq(m, s, ok, ld);
      asserts++;
      if (!ok || obs_wa.size() != exp_wa_q.size() || obs_ra.size() != exp_ra_q.size()) begin
        failures++; $display("FAIL rnd%0d_counts: done %b wr %0d rd %0d expected 1/%0d/%0d", n, ok, obs_wa.size(), obs_ra.size(), exp_wa_q.size(), exp_ra_q.size());
      end
      for (int i = 0; i < obs_wa.size() && i < exp_wa_q.size(); i++) begin
        asserts++;
        if (obs_wa[i] !== exp_wa_q[i] || obs_wd[i] !== exp_wd_q[i]) begin
          failures++; $display("FAIL rnd%0d_wr[%0d]: got %h/%h expected %h/%h", n, i, obs_wa[i], obs_wd[i], exp_wa_q[i], exp_wd_q[i]);
        end
      end
      for (int i = 0; i < obs_ra.size() && i < exp_ra_q.size(); i++) begin
        asserts++;
        if (obs_ra[i] !== exp_ra_q[i]) begin
          failures++; $display("FAIL rnd%0d_raddr[%0d]: got %h expected %h", n, i, obs_ra[i], exp_ra_q[i]);
        end
      end
      asserts++;
      if (ld !== {1'b0, exp_fail, 1'b0, exp_last[12:0]}) begin
        failures++; $display("FAIL rnd%0d_led: got %h expected %h", n, ld, {1'b0, exp_fail, 1'b0, exp_last[12:0]});
      end
      asserts++;
      if (both_cnt != 0) begin failures++; $display("FAIL rnd%0d_exclusive: got %0d expected 0", n, both_cnt); end
    end
    corrupt_idx = -1;
    rd_fixed_en = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_reset_mid_wr();
    test_write_verify();
    test_corrupt();
    test_timeout();
    test_read_only();
    test_busy_ignore();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
